stream_mux_rr: RTL

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 71 +++++++
 rtl/stream_mux_rr.sv | 99 +++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared limits and helpers for the round-robin stream multiplexer.
// Packet-lock support is enabled by defining STREAM_MUX_RR_LAST_EN.
package stream_mux_pkg;

  localparam int unsigned NInMin = 2;
  localparam int unsigned NInMax = 16;
  localparam int unsigned IdxW   = $clog2(NInMax);

  // Encode a one-hot (or all-zero) vector to its bit index; zero maps to 0.
  function automatic logic [IdxW-1:0] onehot_to_idx(input logic [NInMax-1:0] oh);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NInMax; i++) begin
      if (oh[i]) begin
        idx = idx | IdxW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr with wrap-around, and can hold
// its last grant while lock is high (packet mode).
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_IN = 8,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_IN-1:0]  req,
  input  logic             advance,
  input  logic             lock,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] ptr
);

  logic [N_IN-1:0]  grant_rr;
  logic [N_IN-1:0]  grant_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] grant_idx;

  always_comb begin
    int unsigned     pos;
    logic [SEL_W-1:0] pos_s;
    logic            found;
    grant_rr = '0;
    found    = 1'b0;
    pos      = 0;
    pos_s    = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      pos = int'(ptr_q) + i;
      if (pos >= N_IN) begin
        pos = pos - N_IN;
      end
      pos_s = SEL_W'(pos);
      if (!found && req[pos_s]) begin
        grant_rr[pos_s] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  // While locked, only the channel that opened the packet may be granted.
  assign grant = lock ? (grant_q & req) : grant_rr;

  assign grant_idx = SEL_W'(onehot_to_idx(NInMax'(grant)));

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == SEL_W'(N_IN - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (!lock) begin
        grant_q <= grant_rr;
      end
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with round-robin arbitration and one output register.
// Define STREAM_MUX_RR_LAST_EN to add in_last/out_last and packet-granular locking.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N_IN  = 8,
  localparam int unsigned SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
`ifdef STREAM_MUX_RR_LAST_EN
  input  logic [N_IN-1:0]       in_last,
  output logic                  out_last,
`endif
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready
);

  logic             load;
  logic             accept;
  logic             advance;
  logic             lock;
  logic [N_IN-1:0]  grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_src_q;

  assign load     = !out_valid_q || out_ready;
  // Gated by reset so a stale full register cannot accept a beat during reset.
  assign in_ready = grant & {N_IN{load & reset_n}};
  assign accept   = |in_ready;
  assign sel      = SEL_W'(onehot_to_idx(NInMax'(in_ready)));

`ifdef STREAM_MUX_RR_LAST_EN
  logic locked_q;
  logic out_last_q;

  assign advance = accept && in_last[sel];
  assign lock    = locked_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      out_last_q <= 1'b0;
    end else if (accept) begin
      locked_q   <= !in_last[sel];
      out_last_q <= in_last[sel];
    end
  end

  assign out_last = out_last_q;
`else
  assign advance = accept;
  assign lock    = 1'b0;
`endif

  rr_arbiter #(
    .N_IN(N_IN)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (in_valid),
    .advance (advance),
    .lock    (lock),
    .grant   (grant),
    .ptr     (ptr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[sel*WIDTH +: WIDTH];
      out_src_q   <= sel;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  logic unused_ptr;
  assign unused_ptr = ^ptr;

endmodule
